// File: rtl/fpu_wb_pkg.sv
// Shared constants for the FPU Wishbone command-queue front-end.
package fpu_wb_pkg;

  localparam int FLAG_W = 5;

  // Word offsets (wbs_adr_i[4:2]) inside the 32-byte register window
  localparam logic [2:0] OFF_OPA    = 3'd0;
  localparam logic [2:0] OFF_OPB    = 3'd1;
  localparam logic [2:0] OFF_CMD    = 3'd2;
  localparam logic [2:0] OFF_RESULT = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd5;
  localparam logic [2:0] OFF_FLAGS  = 3'd6;

  // STATUS bit positions
  localparam int ST_CMD_FULL  = 0;
  localparam int ST_CMD_EMPTY = 1;
  localparam int ST_RES_EMPTY = 2;
  localparam int ST_RES_FULL  = 3;
  localparam int ST_BUSY      = 4;
  localparam int ST_CMD_CNT   = 8;
  localparam int ST_RES_CNT   = 16;
  localparam int ST_OVF       = 24;
  localparam int ST_UDF       = 25;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} disp_state_e;

  // Byte-lane write merge for 32-bit registers
  function automatic logic [31:0] wb_merge(input logic [31:0] cur, input logic [31:0] nxt,
                                           input logic [3:0] sel);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = nxt[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/fpu_wb_cmdq_sync_fifo.sv
// Single-clock FIFO with occupancy count. Push when full and pop when empty
// are ignored; a pop at full does not make room for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fpu_wb_cmdq.sv
// Wishbone slave that queues FPU commands, dispatches them one at a time
// over a valid/ready port and buffers results for the management core.
module fpu_wb_cmdq
  import fpu_wb_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          OP_W      = 3,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic [2:0]        irq,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [OP_W-1:0]   req_op,
  output logic [DATA_W-1:0] req_a,
  output logic [DATA_W-1:0] req_b,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic [FLAG_W-1:0] rsp_flags
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CMD_W = OP_W + 2*DATA_W;

  logic              hit, we, wr_acc, rd_acc, ctrl_clr;
  logic [2:0]        off;
  logic [3:0]        sel;
  logic [31:0]       wdat, rdata, status;
  logic [DATA_W-1:0] opa, opb;
  logic              irq_en, ovf, udf;
  logic [FLAG_W-1:0] flags;
  logic [1:0]        irq_q;
  disp_state_e       state, state_nx;

  logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CW-1:0]     cmd_cnt;
  logic [CMD_W-1:0]  cmd_head;
  logic              res_push, res_pop, res_full, res_empty;
  logic [CW-1:0]     res_cnt;
  logic [DATA_W-1:0] res_head;
  logic              unused;

  assign unused = ^wbs_adr_i[1:0];

  // Accept a new access only while ack is low, which forces a 2-cycle rhythm
  assign hit = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o &
               (wbs_adr_i[31:5] == BASE_ADDR[31:5]);

  // Latch the access on decode; ack and side effects follow one cycle later
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      off       <= '0;
      we        <= 1'b0;
      sel       <= '0;
      wdat      <= '0;
    end else begin
      wbs_ack_o <= hit;
      if (hit) begin
        off  <= wbs_adr_i[4:2];
        we   <= wbs_we_i;
        sel  <= wbs_sel_i;
        wdat <= wbs_dat_i;
      end
    end
  end

  assign wr_acc   = wbs_ack_o & we;
  assign rd_acc   = wbs_ack_o & ~we;
  assign cmd_push = wr_acc & (off == OFF_CMD);
  assign res_pop  = rd_acc & (off == OFF_RESULT);
  assign ctrl_clr = wr_acc & (off == OFF_CTRL) & sel[0] & wdat[1];

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(cmd_push), .pop(cmd_pop),
    .din({wdat[OP_W-1:0], opa, opb}), .dout(cmd_head),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_cnt)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(res_push), .pop(res_pop),
    .din(rsp_data), .dout(res_head),
    .full(res_full), .empty(res_empty), .count(res_cnt)
  );

  // Operand/control registers and sticky error/flag state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      opa    <= '0;
      opb    <= '0;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      flags  <= '0;
    end else begin
      if (wr_acc && off == OFF_OPA) opa <= wb_merge(opa, wdat, sel);
      if (wr_acc && off == OFF_OPB) opb <= wb_merge(opb, wdat, sel);
      if (wr_acc && off == OFF_CTRL && sel[0]) irq_en <= wdat[0];
      ovf   <= (ovf & ~ctrl_clr) | (cmd_push & cmd_full);
      udf   <= (udf & ~ctrl_clr) | (res_pop & res_empty);
      flags <= (ctrl_clr ? '0 : flags) | (res_push ? rsp_flags : '0);
    end
  end

  // Interrupt lines are registered copies of the enabled conditions
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= '0;
    else          irq_q <= {irq_en & (ovf | udf), irq_en & ~res_empty};
  end
  assign irq = {1'b0, irq_q};

  // STATUS word assembly
  always_comb begin
    status                   = '0;
    status[ST_CMD_FULL]      = cmd_full;
    status[ST_CMD_EMPTY]     = cmd_empty;
    status[ST_RES_EMPTY]     = res_empty;
    status[ST_RES_FULL]      = res_full;
    status[ST_BUSY]          = (state != IDLE);
    status[ST_CMD_CNT +: CW] = cmd_cnt;
    status[ST_RES_CNT +: CW] = res_cnt;
    status[ST_OVF]           = ovf;
    status[ST_UDF]           = udf;
  end

  // Read mux; write-only and unmapped offsets read 0
  always_comb begin
    rdata = '0;
    case (off)
      OFF_OPA:    rdata = opa;
      OFF_OPB:    rdata = opb;
      OFF_RESULT: rdata = res_empty ? '0 : res_head;
      OFF_STATUS: rdata = status;
      OFF_CTRL:   rdata = {31'd0, irq_en};
      OFF_FLAGS:  rdata = {{(32-FLAG_W){1'b0}}, flags};
      default:    rdata = '0;
    endcase
  end
  assign wbs_dat_o = rd_acc ? rdata : '0;

  // Dispatcher state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  // Dispatcher: issue only with result space reserved, one op in flight
  always_comb begin
    state_nx  = state;
    cmd_pop   = 1'b0;
    res_push  = 1'b0;
    req_valid = 1'b0;
    case (state)
      IDLE:    if (!cmd_empty && !res_full) begin
                 cmd_pop  = 1'b1;
                 state_nx = ISSUE;
               end
      ISSUE:   begin
                 req_valid = 1'b1;
                 if (req_ready) state_nx = WAIT;
               end
      WAIT:    if (rsp_valid) begin
                 res_push = 1'b1;
                 state_nx = IDLE;
               end
      default: state_nx = IDLE;
    endcase
  end

  // Request operands held stable from pop until the handshake
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) {req_op, req_a, req_b} <= '0;
    else if (cmd_pop) {req_op, req_a, req_b} <= cmd_head;
  end

endmodule

// File: tb/tb_fpu_wb_cmdq.sv
// Bench for fpu_wb_cmdq: directed scenarios plus a randomized phase checked
// against a queue-based reference of commands, results and sticky flags.
module tb_fpu_wb_cmdq;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [2:0]  R_OPA = 3'd0, R_OPB = 3'd1, R_CMD = 3'd2, R_RES = 3'd3,
                          R_STAT = 3'd4, R_CTRL = 3'd5, R_FLAGS = 3'd6;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0, rdat;
  logic        ack;
  logic [2:0]  irq;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_flags;

  always #5 clk = ~clk;

  fpu_wb_cmdq #(.DATA_W(32), .OP_W(3), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
    .irq(irq), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fpu_fn(input logic [2:0] op, input logic [31:0] a, b);
    return (a + {b[15:0], b[31:16]}) ^ {op, 26'd0, op};
  endfunction

  function automatic logic [4:0] flg_fn(input logic [31:0] a, b);
    return a[4:0] & b[4:0];
  endfunction

  function automatic logic [31:0] st(input bit cf, ce, re, rf, bz, input int cc, rc,
                                     input bit ov, ud);
    return 32'(cf) | (32'(ce) << 1) | (32'(re) << 2) | (32'(rf) << 3) | (32'(bz) << 4) |
           (32'(cc) << 8) | (32'(rc) << 16) | (32'(ov) << 24) | (32'(ud) << 25);
  endfunction

  // FPU model controls (written by the main sequence only)
  bit          fpu_hold = 0, fpu_fast = 1, no_rsp = 0, fix_en = 0;
  int          fpu_lat = 2;
  logic [31:0] fix_data = '0, inj_data = '0;
  logic [4:0]  fix_flags = '0, inj_flags = '0;
  int          inj_seq = 0;

  // FPU model state (owned by the model process)
  bit          pend;
  int          cnt, inj_done;
  logic [2:0]  c_op;
  logic [31:0] c_a, c_b;

  // FPU model: drives on negedge, captures at the handshake, answers after latency
  initial begin
    req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_flags = '0;
    pend = 0; cnt = 0; inj_done = 0; c_op = '0; c_a = '0; c_b = '0;
    forever begin
      @(negedge clk);
      rsp_valid = 0;
      if (inj_done != inj_seq) begin
        inj_done = inj_seq;
        rsp_valid = 1; rsp_data = inj_data; rsp_flags = inj_flags;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          if (!no_rsp) begin
            rsp_valid = 1;
            rsp_data  = fix_en ? fix_data  : fpu_fn(c_op, c_a, c_b);
            rsp_flags = fix_en ? fix_flags : flg_fn(c_a, c_b);
          end
        end
      end
      req_ready = fpu_hold ? 1'b0 : (fpu_fast ? 1'b1 : 1'($urandom_range(0, 1)));
      if (req_valid && req_ready) begin
        pend = 1;
        cnt  = (fpu_lat != 0) ? fpu_lat : int'($urandom_range(1, 4));
        c_op = req_op; c_a = req_a; c_b = req_b;
      end
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output bit acked);
    @(negedge clk);
    stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
    acked = 0; r = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1; r = rdat; break; end
    end
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wb_wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] r; bit k;
    wb_xfer(1'b1, BASE + {27'd0, off, 2'b00}, d, s, r, k);
    chk("wr_ack", 32'(k), 32'd1);
  endtask

  task automatic wb_rd(input logic [2:0] off, output logic [31:0] d);
    bit k;
    wb_xfer(1'b0, BASE + {27'd0, off, 2'b00}, '0, 4'hF, d, k);
    chk("rd_ack", 32'(k), 32'd1);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] d, s, a2, b2, ra, rb;
  logic [2:0]  rop;
  logic [31:0] exp_q[$];
  logic [4:0]  exp_flags;
  int          outst;
  bit          k;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_wait(3);
    @(negedge clk); rst = 0;
    cyc_wait(1);

    // Reset state
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", rdat, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_req_valid", 32'(req_valid), 0);
    wb_rd(R_STAT, d); chk("rst_status", d, st(0,1,1,0,0,0,0,0,0));

    // Byte-lane writes and unmapped offset
    wb_wr(R_OPA, 32'h1122_3344);
    wb_wr(R_OPA, 32'hAABB_CCDD, 4'b0101);
    wb_rd(R_OPA, d); chk("opa_bytesel", d, 32'h11BB_33DD);
    wb_rd(3'd7, d); chk("unmapped_rd", d, 0);

    // Single op: 1.0 + 2.0 -> 3.0
    wb_wr(R_CTRL, 32'h1);
    fix_en = 1; fix_data = 32'h4040_0000; fix_flags = 0; fpu_lat = 3; fpu_fast = 1;
    wb_wr(R_OPA, 32'h3F80_0000);
    wb_wr(R_OPB, 32'h4000_0000);
    wb_wr(R_CMD, 32'h0);
    cyc_wait(12);
    wb_rd(R_STAT, d); chk("t1_status", d, st(0,1,0,0,0,0,1,0,0));
    chk("t1_irq_res", 32'(irq), 32'h1);
    wb_rd(R_RES, d); chk("t1_result", d, 32'h4040_0000);
    wb_rd(R_STAT, d); chk("t1_status_empty", d, st(0,1,1,0,0,0,0,0,0));
    wb_rd(R_FLAGS, d); chk("t1_flags", d, 0);
    fix_en = 0;

    // Stall the FPU: fill the command FIFO, overflow, clear
    fpu_hold = 1; fpu_lat = 2;
    a2 = 32'h3F80_0000; b2 = 32'h40A0_0000;
    wb_wr(R_OPA, a2); wb_wr(R_OPB, b2);
    for (int i = 0; i < 5; i++) wb_wr(R_CMD, 32'(i));
    cyc_wait(2);
    wb_rd(R_STAT, d); chk("t2_full", d, st(1,0,1,0,1,4,0,0,0));
    chk("t2_req_valid", 32'(req_valid), 1);
    chk("t2_req_op", 32'(req_op), 0);
    chk("t2_req_a", req_a, a2);
    wb_wr(R_CMD, 32'h5);
    wb_rd(R_STAT, d); chk("t2_ovf", d, st(1,0,1,0,1,4,0,1,0));
    cyc_wait(2);
    chk("t2_irq_err", 32'(irq), 32'h2);
    wb_wr(R_CTRL, 32'h3);
    wb_rd(R_STAT, d); chk("t2_ovf_clr", d, st(1,0,1,0,1,4,0,0,0));

    // Release: result FIFO fills, dispatcher parks with one command pending
    fpu_hold = 0; fpu_fast = 1;
    cyc_wait(40);
    wb_rd(R_STAT, d); chk("t4_res_full", d, st(0,0,0,1,0,1,4,0,0));
    wb_rd(R_RES, d); chk("t4_res0", d, fpu_fn(3'd0, a2, b2));
    wb_rd(R_STAT, d); chk("t4_resume", d, st(0,1,0,0,1,0,3,0,0));
    cyc_wait(10);
    for (int i = 1; i < 5; i++) begin
      wb_rd(R_RES, d); chk("t4_res", d, fpu_fn(3'(i), a2, b2));
    end
    wb_rd(R_STAT, d); chk("t4_drained", d, st(0,1,1,0,0,0,0,0,0));

    // Underflow on empty RESULT read
    wb_rd(R_RES, d); chk("t3_udf_data", d, 0);
    wb_rd(R_STAT, d); chk("t3_udf", d, st(0,1,1,0,0,0,0,0,1));
    cyc_wait(2);
    chk("t3_irq_err", 32'(irq), 32'h2);
    wb_wr(R_CTRL, 32'h3);
    cyc_wait(3);
    chk("t3_irq_clr", 32'(irq), 0);

    // Sticky flags: NX then OF
    fix_en = 1; fix_data = 32'hDEAD_0001; fix_flags = 5'h01;
    wb_wr(R_CMD, 32'h1);
    cyc_wait(10);
    fix_flags = 5'h04;
    wb_wr(R_CMD, 32'h2);
    cyc_wait(10);
    wb_rd(R_FLAGS, d); chk("t5_flags", d, 32'h05);
    wb_rd(R_RES, d); chk("t5_res_a", d, 32'hDEAD_0001);
    wb_rd(R_RES, d); chk("t5_res_b", d, 32'hDEAD_0001);
    wb_rd(R_FLAGS, d); chk("t5_flags_kept", d, 32'h05);
    wb_wr(R_CTRL, 32'h3);
    wb_rd(R_FLAGS, d); chk("t5_flags_clr", d, 0);
    fix_en = 0;

    // Randomized traffic against the queue reference
    fpu_fast = 0; fpu_lat = 0; outst = 0; exp_flags = '0;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 1 && outst < DEPTH) begin
        ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7));
        wb_wr(R_OPA, ra); wb_wr(R_OPB, rb); wb_wr(R_CMD, {29'd0, rop});
        exp_q.push_back(fpu_fn(rop, ra, rb));
        exp_flags |= flg_fn(ra, rb);
        outst++;
      end else begin
        wb_rd(R_STAT, s);
        chk("rand_occupancy", 32'(s[11:8]) + 32'(s[19:16]) + 32'(s[4]), 32'(outst));
        if (!s[2]) begin
          wb_rd(R_RES, d);
          if (exp_q.size() == 0) chk("rand_extra_result", 32'd1, 32'd0);
          else begin chk("rand_result", d, exp_q.pop_front()); outst--; end
        end
      end
    end
    for (int t = 0; t < 200 && outst > 0; t++) begin
      wb_rd(R_STAT, s);
      if (!s[2]) begin
        wb_rd(R_RES, d);
        if (exp_q.size() == 0) chk("drain_extra_result", 32'd1, 32'd0);
        else begin chk("drain_result", d, exp_q.pop_front()); outst--; end
      end
    end
    chk("rand_drained", 32'(outst), 0);
    wb_rd(R_FLAGS, d); chk("rand_flags", d, 32'(exp_flags));

    // Reset during WAIT; late response must be ignored
    fpu_fast = 1; fpu_lat = 2; no_rsp = 0;
    wb_wr(R_CMD, 32'h3);
    cyc_wait(10);
    chk("t6_irq_pre", 32'(irq), 32'h1);
    no_rsp = 1;
    wb_wr(R_CMD, 32'h4);
    cyc_wait(4);
    wb_rd(R_STAT, d); chk("t6_in_wait", d, st(0,1,0,0,1,0,1,0,0));
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    inj_data = 32'hBAD0_BAD0; inj_flags = 5'h1F; inj_seq++;
    cyc_wait(5);
    chk("t6_irq", 32'(irq), 0);
    chk("t6_req_valid", 32'(req_valid), 0);
    wb_rd(R_STAT, d); chk("t6_status", d, st(0,1,1,0,0,0,0,0,0));
    wb_rd(R_FLAGS, d); chk("t6_flags", d, 0);
    wb_xfer(1'b0, BASE + 32'h20, '0, 4'hF, d, k);
    chk("miss_no_ack", 32'(k), 0);
    chk("miss_dat", rdat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_wb_cmdq.md
Name: fpu_wb_cmdq

Overview:
- Wishbone slave front-end that decouples the Caravel management core from the FPU datapath.
- Buffers operation commands in a DEPTH-entry command FIFO and dispatches them to the FPU core over a valid/ready request port.
- Collects FPU results into a DEPTH-entry result FIFO and raises user interrupts.
- Sits between the wrapper's wbs_* bus and the FPU core; replaces direct single-operation register access.

Parameters:
- DATA_W, 32, operand/result width (must be 32 for the Wishbone data path).
- OP_W, 3, FPU opcode width.
- DEPTH, 4, entries in each FIFO; power of two, >=2.
- BASE_ADDR, 32'h3000_0000, block base; decode matches wbs_adr_i[31:5] == BASE_ADDR[31:5].

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe / cycle / write enable
- wbs_sel_i  in  4  byte selects; writes honour per byte
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  acknowledge
- irq  out  3  [0] result available, [1] error, [2] tied 0
- req_valid  out  1  FPU request valid
- req_ready  in  1  FPU request accept
- req_op  out  OP_W  opcode
- req_a, req_b  out  DATA_W  operands
- rsp_valid  in  1  FPU result strobe (1 cycle)
- rsp_data  in  DATA_W  result
- rsp_flags  in  5  IEEE flags NV,DZ,OF,UF,NX

Behaviour:
- One clock (wb_clk_i); reset is synchronous and active-high (wb_rst_i). Reset clears all registers, FIFOs, errors and FLAGS; FSM -> IDLE. All outputs reset to 0.
- Bus timing: a selected access (stb&cyc&decode hit, ack low) gives wbs_ack_o=1 on the next cycle for exactly one cycle. ack is forced low the cycle after, so back-to-back accesses take 2 cycles each.
- Bus side effects: occur in the ack cycle only. wbs_dat_o is valid with ack and is 0 otherwise.
- Decode miss: no ack.
- Register map (offset):
  - 0x00 OPA RW
  - 0x04 OPB RW
  - 0x08 CMD W: bits[OP_W-1:0]=op; pushes {op,OPA,OPB}.
  - 0x0C RESULT R: pops head.
  - 0x10 STATUS R: [0]cmd_full [1]cmd_empty [2]res_empty [3]res_full [4]busy(FSM!=IDLE) [11:8]cmd_count [19:16]res_count [24]ovf [25]udf.
  - 0x14 CTRL RW: [0]irq_en; bit[1] is write-1-clears ovf/udf/FLAGS and reads 0.
  - 0x18 FLAGS R: sticky OR of rsp_flags in [4:0].
  - Other offsets in range: ack, read 0, writes ignored.
- CMD write when cmd FIFO is full: acked, command dropped, ovf set (sticky).
- RESULT read when result FIFO is empty: returns 0, udf set (sticky).
- Dispatcher FSM:
  - IDLE: if cmd not empty and res_count < DEPTH, pop the head into the request registers -> ISSUE.
  - ISSUE: req_valid=1 with stable op/a/b until req_ready; the handshake cycle -> WAIT.
  - WAIT: on rsp_valid, push rsp_data into the result FIFO, OR rsp_flags into FLAGS -> IDLE.
  - Only one operation is outstanding at a time, so result-FIFO space is guaranteed before issue.
  - rsp_valid in IDLE or ISSUE is ignored.
- Minimum command-to-result-visible latency: CMD ack cycle + 1 (IDLE pop) + req handshake + FPU latency + 1 (result push).
- Simultaneous CMD push and dispatcher pop on the same cycle: both occur, count unchanged. The same applies to simultaneous RESULT pop and result push. The FIFO pop when at count DEPTH frees space the same cycle only for the pusher on the next cycle (no same-cycle full bypass).
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- irq[0] and irq[1] are registered: irq[0] = irq_en & !res_empty; irq[1] = irq_en & (ovf|udf).
- Reset mid-operation: the in-flight FPU op is abandoned and a later rsp_valid is ignored.

Decomposition:
- Package fpu_wb_pkg: register offset constants, STATUS bit positions, dispatcher state enum (IDLE/ISSUE/WAIT), flag-width constant.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice: command entries of width OP_W+2*DATA_W, result entries of width DATA_W.

Test Plan:
- Write OPA=0x3F800000, OPB=0x40000000, CMD=op 0; FPU model returns 0x40400000 after 3 cycles with flags 0 -> STATUS.res_count=1, RESULT reads 0x40400000, res_empty=1 afterwards.
- FPU model holds req_ready=0: write 5 CMDs with DEPTH=4 -> first popped to ISSUE, 4 queued, STATUS.cmd_full=1. The 6th CMD sets ovf=1 and is acked; CTRL write 0x2 clears ovf.
- Read RESULT while empty -> data 0, udf=1, irq[1]=1 with irq_en=1.
- 4 results fill the result FIFO -> FSM stays IDLE with cmd pending (busy=0, res_full=1). A single RESULT read lets dispatch resume the next cycle.
- Response flags NX then OF -> FLAGS reads 0x05 (OF|NX), retained until CTRL bit1 write.
- Assert wb_rst_i during WAIT, then drive rsp_valid -> all counts 0, irq=0, req_valid=0, no result pushed; an access outside BASE_ADDR gets no ack.
